// File: rtl/driver_column_scanner.sv
// Column scanner for a 5x7 LED matrix. It loads frames through a double buffer and swaps them only at a scan wrap.
// Optional anti-ghosting blank cycle at the start of each column slot: define DRIVER_SCAN_BLANK_EN.
module driver_column_scanner #(
    parameter int PRESCALE_DIV = 50000,
    parameter int NUM_COLS     = 5,
    parameter int NUM_ROWS     = 7
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         enable,
    input  logic [NUM_COLS*NUM_ROWS-1:0] frame_data,
    input  logic                         frame_valid,
    output logic                         frame_ready,
    output logic [2:0]                   bin_number,
    output logic [NUM_ROWS-1:0]          row_data,
    output logic                         frame_start
);

    localparam int              PW       = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
    localparam int              FW       = NUM_COLS * NUM_ROWS;
    localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE_DIV - 1);
    localparam logic [2:0]      COL_LAST = 3'(NUM_COLS - 1);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t              state;
    state_t              state_next;
    logic [PW-1:0]       prescaler;
    logic [2:0]          column;
    logic [2:0]          column_next;
    logic [FW-1:0]       pending;
    logic [FW-1:0]       active;
    logic [FW-1:0]       active_next;
    logic [NUM_ROWS-1:0] row_next;
    logic                tick;
    logic                wrap;
    logic                accept;
    logic                swap;

    assign tick       = enable && (prescaler == PRE_LAST);
    assign wrap       = tick && (column == COL_LAST);
    assign bin_number = column;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= EMPTY;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            EMPTY:   if (frame_valid) state_next = FULL;
            FULL:    if (wrap)        state_next = EMPTY;
            default:                  state_next = EMPTY;
        endcase
    end

    always_comb begin
        frame_ready = (state == EMPTY);
        accept      = (state == EMPTY) && frame_valid;
        swap        = (state == FULL) && wrap;
    end

    // Row pattern is computed from next-cycle column/frame so it lands together with bin_number.
    always_comb begin
        column_next = column;
        if (tick) begin
            column_next = wrap ? 3'd0 : column + 3'd1;
        end
        active_next = swap ? pending : active;
        row_next    = '0;
`ifdef DRIVER_SCAN_BLANK_EN
        if (enable && !tick) begin
            row_next = active_next[int'(column_next) * NUM_ROWS +: NUM_ROWS];
        end
`else
        if (enable) begin
            row_next = active_next[int'(column_next) * NUM_ROWS +: NUM_ROWS];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
        end else if (enable) begin
            prescaler <= tick ? '0 : prescaler + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            column      <= 3'd0;
            pending     <= '0;
            active      <= '0;
            row_data    <= '0;
            frame_start <= 1'b0;
        end else begin
            column      <= column_next;
            active      <= active_next;
            row_data    <= row_next;
            frame_start <= wrap;
            if (accept) begin
                pending <= frame_data;
            end
        end
    end

endmodule

// File: tb/tb_driver_column_scanner.sv
// Directed, table-driven bench for driver_column_scanner (PRESCALE_DIV=4), plus a fast-prescale instance.
module tb_driver_column_scanner;

    localparam int DIV = 4;
`ifdef DRIVER_SCAN_BLANK_EN
    localparam bit BLANK = 1'b1;
    localparam int DIV2  = 2;
`else
    localparam bit BLANK = 1'b0;
    localparam int DIV2  = 1;
`endif

    typedef struct {
        logic        rst;
        logic        en;
        logic        valid;
        logic [34:0] data;
        logic [2:0]  bin;
        logic [6:0]  row;
        logic        ready;
        logic        start;
        logic        slot_first;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [34:0] frame_data;
    logic        frame_valid;
    logic        frame_ready;
    logic [2:0]  bin_number;
    logic [6:0]  row_data;
    logic        frame_start;

    logic        reset2;
    logic        enable2;
    logic [34:0] frame_data2;
    logic        frame_valid2;
    logic        frame_ready2;
    logic [2:0]  bin_number2;
    logic [6:0]  row_data2;
    logic        frame_start2;

    int checks = 0;
    int errors = 0;
    vec_t vecs[$];

    logic [34:0] f1;
    logic [34:0] f2;
    logic [34:0] f3;
    logic [34:0] junk;

    always #5 clk = ~clk;

    driver_column_scanner #(.PRESCALE_DIV(DIV)) dut (
        .clk(clk), .reset(reset), .enable(enable), .frame_data(frame_data),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .bin_number(bin_number),
        .row_data(row_data), .frame_start(frame_start)
    );

    driver_column_scanner #(.PRESCALE_DIV(DIV2)) dut_fast (
        .clk(clk), .reset(reset2), .enable(enable2), .frame_data(frame_data2),
        .frame_valid(frame_valid2), .frame_ready(frame_ready2), .bin_number(bin_number2),
        .row_data(row_data2), .frame_start(frame_start2)
    );

    task automatic check(input string name, input int idx, input logic [34:0] got, input logic [34:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at step %0d: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic add(input int n, input logic rst, input logic en, input logic valid,
                       input logic [34:0] data, input logic [2:0] bin, input logic [6:0] row,
                       input logic ready, input logic start, input logic slot_first);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.rst        = rst;
            v.en         = en;
            v.valid      = valid;
            v.data       = data;
            v.bin        = bin;
            v.row        = row;
            v.ready      = ready;
            v.start      = start && (i == 0);
            v.slot_first = slot_first && (i == 0);
            vecs.push_back(v);
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        reset       = v.rst;
        enable      = v.en;
        frame_valid = v.valid;
        frame_data  = v.data;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input int idx, input vec_t v);
        logic [6:0] exp_row;
        exp_row = (BLANK && v.slot_first) ? 7'h00 : v.row;
        check("bin_number", idx, 35'(bin_number), 35'(v.bin));
        check("row_data", idx, 35'(row_data), 35'(exp_row));
        check("frame_ready", idx, 35'(frame_ready), 35'(v.ready));
        check("frame_start", idx, 35'(frame_start), 35'(v.start));
    endtask

    initial begin
        f1   = 35'h4_0C30_8181;
        f2   = {7'h55, 7'h00, 7'h7F, 7'h15, 7'h2A};
        f3   = {7'h11, 7'h22, 7'h33, 7'h44, 7'h08};
        junk = 35'h5_5555_5555;

        // rst en val data  bin row    rdy st first
        add(3, 0, 1, 0, junk, 0, 7'h00, 1, 0, 0);
        add(4, 0, 1, 0, junk, 1, 7'h00, 1, 0, 1);
        add(1, 0, 1, 0, junk, 2, 7'h00, 1, 0, 1);
        add(1, 0, 1, 1, f1,   2, 7'h00, 0, 0, 0);
        add(2, 0, 1, 0, junk, 2, 7'h00, 0, 0, 0);
        add(4, 0, 1, 0, junk, 3, 7'h00, 0, 0, 1);
        add(4, 0, 1, 0, junk, 4, 7'h00, 0, 0, 1);
        add(1, 0, 1, 0, junk, 0, 7'h01, 1, 1, 1);
        add(1, 0, 1, 1, f2,   0, 7'h01, 0, 0, 0);
        add(2, 0, 1, 1, f3,   0, 7'h01, 0, 0, 0);
        add(4, 0, 1, 1, f3,   1, 7'h03, 0, 0, 1);
        add(4, 0, 1, 1, f3,   2, 7'h42, 0, 0, 1);
        add(4, 0, 1, 1, f3,   3, 7'h61, 0, 0, 1);
        add(4, 0, 1, 1, f3,   4, 7'h40, 0, 0, 1);
        add(1, 0, 1, 1, f3,   0, 7'h2A, 1, 1, 1);
        add(1, 0, 1, 1, f3,   0, 7'h2A, 0, 0, 0);
        add(2, 0, 1, 0, junk, 0, 7'h2A, 0, 0, 0);
        add(4, 0, 1, 0, junk, 1, 7'h15, 0, 0, 1);
        add(4, 0, 1, 0, junk, 2, 7'h7F, 0, 0, 1);
        add(4, 0, 1, 0, junk, 3, 7'h00, 0, 0, 1);
        add(4, 0, 1, 0, junk, 4, 7'h55, 0, 0, 1);
        add(1, 0, 1, 0, junk, 0, 7'h08, 1, 1, 1);
        add(3, 0, 1, 0, junk, 0, 7'h08, 1, 0, 0);
        add(4, 0, 1, 0, junk, 1, 7'h44, 1, 0, 1);
        add(4, 0, 1, 0, junk, 2, 7'h33, 1, 0, 1);
        add(4, 0, 1, 0, junk, 3, 7'h22, 1, 0, 1);
        add(4, 0, 1, 0, junk, 4, 7'h11, 1, 0, 1);
        // frame offered on the wrap tick while EMPTY: stored, old frame keeps showing
        add(1, 0, 1, 1, f1,   0, 7'h08, 0, 1, 1);
        add(3, 0, 1, 0, junk, 0, 7'h08, 0, 0, 0);
        add(4, 0, 1, 0, junk, 1, 7'h44, 0, 0, 1);
        add(4, 0, 1, 0, junk, 2, 7'h33, 0, 0, 1);
        add(4, 0, 1, 0, junk, 3, 7'h22, 0, 0, 1);
        add(4, 0, 1, 0, junk, 4, 7'h11, 0, 0, 1);
        add(1, 0, 1, 0, junk, 0, 7'h01, 1, 1, 1);
        add(3, 0, 1, 0, junk, 0, 7'h01, 1, 0, 0);
        add(4, 0, 1, 0, junk, 1, 7'h03, 1, 0, 1);
        add(4, 0, 1, 0, junk, 2, 7'h42, 1, 0, 1);
        add(2, 0, 1, 0, junk, 3, 7'h61, 1, 0, 1);
        // enable low for 10 cycles in column 3
        add(10, 0, 0, 0, junk, 3, 7'h00, 1, 0, 0);
        add(2, 0, 1, 0, junk, 3, 7'h61, 1, 0, 0);
        add(4, 0, 1, 0, junk, 4, 7'h40, 1, 0, 1);
        add(1, 0, 1, 0, junk, 0, 7'h01, 1, 1, 1);
        add(1, 0, 1, 1, f2,   0, 7'h01, 0, 0, 0);
        add(2, 0, 1, 0, junk, 0, 7'h01, 0, 0, 0);
        add(4, 0, 1, 0, junk, 1, 7'h03, 0, 0, 1);
        add(4, 0, 1, 0, junk, 2, 7'h42, 0, 0, 1);
        add(2, 0, 1, 0, junk, 3, 7'h61, 0, 0, 1);
        // reset mid column 3 with a pending frame
        add(1, 1, 1, 0, junk, 0, 7'h00, 1, 0, 0);
        add(3, 0, 1, 0, junk, 0, 7'h00, 1, 0, 0);
        add(4, 0, 1, 0, junk, 1, 7'h00, 1, 0, 1);
        add(4, 0, 1, 0, junk, 2, 7'h00, 1, 0, 1);
        add(4, 0, 1, 0, junk, 3, 7'h00, 1, 0, 1);
        add(4, 0, 1, 0, junk, 4, 7'h00, 1, 0, 1);
        add(1, 0, 1, 0, junk, 0, 7'h00, 1, 1, 1);
        add(3, 0, 1, 0, junk, 0, 7'h00, 1, 0, 0);

        reset        = 1'b1;
        enable       = 1'b1;
        frame_valid  = 1'b1;
        frame_data   = f2;
        reset2       = 1'b1;
        enable2      = 1'b0;
        frame_valid2 = 1'b0;
        frame_data2  = '0;
        repeat (2) @(posedge clk);
        #1;

        // fast-prescale instance: bin_number steps every DIV2 cycles, wrap pulse at each return to 0
        reset2  = 1'b0;
        enable2 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            check("fast bin_number", k, 35'(bin_number2), 35'((k / DIV2) % 5));
            check("fast frame_start", k, 35'(frame_start2), 35'((k % (5 * DIV2)) == 0));
        end

        // main instance has been held in reset with enable and frame_valid high
        check("reset bin_number", 0, 35'(bin_number), 35'd0);
        check("reset row_data", 0, 35'(row_data), 35'd0);
        check("reset frame_ready", 0, 35'(frame_ready), 35'd1);
        check("reset frame_start", 0, 35'(frame_start), 35'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            check_output(i + 1, vecs[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/driver_column_scanner.md
Name: driver_column_scanner

Overview:
- Upstream stage of the LED-matrix column decoder. Time-multiplexes a 5-column x 7-row frame.
- Produces the 3-bit column index `bin_number` that the decoder expands to one-hot column enables.
- Produces the matching 7-bit row pattern for the selected column.
- Double-buffered frame load with valid/ready handshake; a new frame is swapped in only at a full-scan boundary, so frames never tear.

Parameters:
- PRESCALE_DIV, 50000, clock cycles each column stays selected; legal range >= 1 (>= 2 when BLANK_EN is defined).
- NUM_COLS, 5, number of matrix columns; fixed at 5 to match the decoder.
- NUM_ROWS, 7, rows per column.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  scan run; 0 = freeze scan and blank rows.
- frame_data  input  35  new frame; bit c*7+r = row r of column c (1 = LED on).
- frame_valid  input  1  frame_data is valid.
- frame_ready  output  1  pending buffer is free; a frame can be accepted.
- bin_number  output  3  selected column index, 0..4; feeds the column decoder.
- row_data  output  7  row pattern for the selected column.
- frame_start  output  1  one-cycle pulse when the scan returns to column 0.

Behaviour:
- One clock domain. Synchronous, active-high reset.
- Reset values: prescaler=0, column=0, active buffer=0, pending buffer empty.
  - Outputs after reset: bin_number=0, row_data=0, frame_ready=1, frame_start=0.
- Reset mid-operation discards the pending frame, clears the active frame and restarts at column 0.
- Prescaler:
  - When enable=1, it counts 0..PRESCALE_DIV-1 and wraps.
  - tick = enable && prescaler==PRESCALE_DIV-1.
  - PRESCALE_DIV=1 gives a tick every enabled cycle.
- Column counter:
  - Advances on tick as 0->1->2->3->4->0.
  - Values 5..7 are never produced.
  - The new column is visible on bin_number the cycle after tick.
- State machine over the pending buffer:
  - EMPTY: frame_ready=1. On frame_valid, capture frame_data into pending and go to FULL.
  - FULL: frame_ready=0, frame_valid is ignored.
    - Leave on the wrap tick (column 4 and tick): active <= pending, go to EMPTY.
- Simultaneous events:
  - Accept in EMPTY during a wrap tick: the frame is stored in pending and not swapped; it is shown from the next wrap.
  - Swap in FULL with frame_valid high: the swap happens, frame_ready rises the next cycle, and the frame is not accepted this cycle.
- Handshake:
  - A transfer occurs only when frame_valid && frame_ready in the same cycle.
  - frame_data is sampled only on that cycle.
  - frame_ready is registered and does not depend combinationally on frame_valid.
- row_data:
  - Registered. Equals active[column*7 +: 7] for the column on bin_number, and is aligned with bin_number in the same cycle.
  - After a swap, the new frame appears together with bin_number=0.
- frame_start:
  - Registered. High for exactly one cycle, the same cycle bin_number becomes 0 from 4.
  - Not asserted out of reset.
- enable=0:
  - Prescaler, column and bin_number hold.
  - row_data=0 from the next cycle; no frame_start.
  - The handshake still operates, but no swap occurs while disabled.
  - enable returning to 1 resumes from the held prescaler value.

Optional Feature:
- Macro: DRIVER_SCAN_BLANK_EN.
- Defined (anti-ghosting):
  - row_data is forced to 0 during the first cycle of every column slot, i.e. the cycle bin_number changes.
  - Real pattern from the second cycle of the slot; bin_number timing is unchanged.
  - Requires PRESCALE_DIV >= 2.
- Undefined: no blanking cycle; row_data changes in the same cycle as bin_number.

Test Plan:
- Reset with PRESCALE_DIV=4, enable=1, no frame loaded:
  - Expect bin_number 0,1,2,3,4,0 with 4 cycles per column.
  - Expect frame_start one cycle at each return to 0.
  - Expect row_data=0 throughout.
- Load frame_data=35'h4_0C30_8181 in column 2:
  - frame_ready falls to 0 the next cycle.
  - Current scan finishes with zeros.
  - At the next bin_number=0, row_data=frame_data[6:0]; column 1 shows bits [13:7], and so on.
  - frame_ready=1 the cycle after the swap.
- Hold frame_valid high while FULL with a second frame:
  - Second frame is not accepted until frame_ready=1.
  - Then it is accepted and shown one scan later; no tearing mid-scan.
- Assert frame_valid in the wrap-tick cycle while EMPTY:
  - Frame is stored, not displayed on this wrap.
  - It is displayed at the following wrap.
- Drop enable for 10 cycles at column 3:
  - bin_number stays 3 and row_data=0.
  - On re-enable, column 3 completes its remaining cycles.
- Reset in the middle of column 3 with a pending frame:
  - All outputs return to reset values, frame_ready=1, pending frame lost.
- With DRIVER_SCAN_BLANK_EN defined and PRESCALE_DIV=4:
  - row_data is 0 on the first cycle of each column slot.
  - row_data carries the pattern on the remaining 3 cycles.
